// File: rtl/onewire_rom_reader_pkg.sv
// Shared definitions for the 1-Wire ROM reader: FSM state codes, the
// Dallas CRC-8 polynomial, default bus timings and a serial CRC step.
package onewire_rom_reader_pkg;

  // FSM state codes
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RST_LOW = 3'd1;
  localparam logic [2:0] PD_WAIT = 3'd2;
  localparam logic [2:0] PD_REST = 3'd3;
  localparam logic [2:0] WR_SLOT = 3'd4;
  localparam logic [2:0] RD_SLOT = 3'd5;
  localparam logic [2:0] CHECK   = 3'd6;
  localparam logic [2:0] FINISH  = 3'd7;

  // x^8+x^5+x^4+1 in reflected form
  localparam logic [7:0] CRC8_POLY = 8'h8C;

  // Standard-speed bus timings in microseconds
  localparam int DEF_T_RSTL = 480;
  localparam int DEF_T_PDS  = 70;
  localparam int DEF_T_RSTH = 410;
  localparam int DEF_T_SLOT = 70;
  localparam int DEF_T_LOW1 = 6;
  localparam int DEF_T_LOW0 = 60;
  localparam int DEF_T_RDS  = 15;

  // One serial CRC-8 step, LSB-first data
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[0] ^ bit_in;
    return {1'b0, crc[7:1]} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8 accumulator, one data bit per enabled cycle.
module onewire_crc8
  import onewire_rom_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  // Clear takes priority so a new transaction always starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     crc <= 8'h00;
    else if (clr)  crc <= 8'h00;
    else if (en)   crc <= crc8_step(crc, bit_in);
  end

endmodule

// File: rtl/onewire_rom_reader.sv
// 1-Wire bus master: reset/presence, one command byte, then NBYTES read
// bytes with optional CRC-8 check. Drives an open-drain pad via dq_oe.
//
// Handshake: go is a single-cycle request honoured only while idle; busy is
// high from the cycle after acceptance until done, which pulses for exactly
// one cycle at the end of every transaction (including presence failure).
module onewire_rom_reader
  import onewire_rom_reader_pkg::*;
#(
  parameter int         CLK_HZ    = 100_000_000,
  parameter logic [7:0] CMD       = 8'h33,
  parameter int         NBYTES    = 8,
  parameter int         CRC_CHECK = 1,
  parameter int         T_RSTL    = DEF_T_RSTL,
  parameter int         T_PDS     = DEF_T_PDS,
  parameter int         T_RSTH    = DEF_T_RSTH,
  parameter int         T_SLOT    = DEF_T_SLOT,
  parameter int         T_LOW1    = DEF_T_LOW1,
  parameter int         T_LOW0    = DEF_T_LOW0,
  parameter int         T_RDS     = DEF_T_RDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  dq_i,
  output logic                  dq_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  err_nopresence,
  output logic                  err_crc,
  output logic [8*NBYTES-1:0]   data,
  output logic                  valid
);

  localparam int DIV   = CLK_HZ / 1_000_000;
  localparam int DW    = $clog2(DIV);
  localparam int NBITS = 8 * NBYTES;
  localparam int BW    = $clog2(NBITS);
  localparam int T_MAX = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
  localparam int UW    = $clog2(T_MAX + 1);

  // Phase events fire on the tick that moves the counter to the target,
  // so a state entered on a tick lasts exactly the programmed time.
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [UW-1:0] RSTL_END = UW'(T_RSTL - 1);
  localparam logic [UW-1:0] PDS_AT   = UW'(T_PDS - 1);
  localparam logic [UW-1:0] RSTH_END = UW'(T_RSTH - 1);
  localparam logic [UW-1:0] SLOT_END = UW'(T_SLOT - 1);
  localparam logic [UW-1:0] RDS_AT   = UW'(T_RDS - 1);
  localparam logic [UW-1:0] LOW1_US  = UW'(T_LOW1);
  localparam logic [UW-1:0] LOW0_US  = UW'(T_LOW0);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [UW-1:0] us_cnt;
  logic [2:0]    state;
  logic [BW-1:0] bit_idx;
  logic          dq_meta;
  logic          dq_s;
  logic [7:0]    crc_val;
  logic          crc_clr;
  logic          crc_en;
  logic [UW-1:0] wr_low;
  logic          slot_end;
  logic          rd_sample;

  assign tick      = (div_cnt == DIV_LAST);
  assign wr_low    = CMD[bit_idx[2:0]] ? LOW1_US : LOW0_US;
  assign slot_end  = tick && (us_cnt == SLOT_END);
  assign rd_sample = (state == RD_SLOT) && tick && (us_cnt == RDS_AT);
  assign crc_clr   = (state == IDLE) && go;
  assign crc_en    = rd_sample;

  // Free-running microsecond divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Two-flop synchroniser for the asynchronous bus level (idle bus is high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_meta <= 1'b1;
      dq_s    <= 1'b1;
    end else begin
      dq_meta <= dq_i;
      dq_s    <= dq_meta;
    end
  end

  // Transaction sequencer: phase counter, bit index, status and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      us_cnt         <= '0;
      bit_idx        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_nopresence <= 1'b0;
      err_crc        <= 1'b0;
      valid          <= 1'b0;
      data           <= '0;
    end else begin
      done <= 1'b0;
      if (tick && state != IDLE) us_cnt <= us_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (go) begin
            busy           <= 1'b1;
            err_nopresence <= 1'b0;
            err_crc        <= 1'b0;
            valid          <= 1'b0;
            us_cnt         <= '0;
            bit_idx        <= '0;
            state          <= RST_LOW;
          end
        end
        RST_LOW: begin
          if (tick && us_cnt == RSTL_END) begin
            us_cnt <= '0;
            state  <= PD_WAIT;
          end
        end
        PD_WAIT: begin
          // Counter keeps running into PD_REST: both are timed from release
          if (tick && us_cnt == PDS_AT) begin
            if (dq_s) begin
              err_nopresence <= 1'b1;
              done           <= 1'b1;
              busy           <= 1'b0;
              state          <= FINISH;
            end else begin
              state <= PD_REST;
            end
          end
        end
        PD_REST: begin
          if (tick && us_cnt == RSTH_END) begin
            us_cnt  <= '0;
            bit_idx <= '0;
            state   <= WR_SLOT;
          end
        end
        WR_SLOT: begin
          if (slot_end) begin
            us_cnt <= '0;
            if (bit_idx[2:0] == 3'd7) begin
              bit_idx <= '0;
              state   <= RD_SLOT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        RD_SLOT: begin
          if (rd_sample) data[bit_idx] <= dq_s;
          if (slot_end) begin
            us_cnt <= '0;
            if (bit_idx == LAST_BIT) state   <= CHECK;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        CHECK: begin
          // A good ROM including its CRC byte leaves the register at zero
          if (CRC_CHECK != 0 && crc_val != 8'h00) begin
            err_crc <= 1'b1;
            valid   <= 1'b0;
          end else begin
            valid <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= FINISH;
        end
        FINISH: begin
          us_cnt  <= '0;
          bit_idx <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered open-drain enable: glitch-free, released at once by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_oe <= 1'b0;
    end else begin
      case (state)
        RST_LOW: dq_oe <= 1'b1;
        WR_SLOT: dq_oe <= (us_cnt < wr_low);
        RD_SLOT: dq_oe <= (us_cnt < LOW1_US);
        default: dq_oe <= 1'b0;
      endcase
    end
  end

  onewire_crc8 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (dq_s),
    .crc    (crc_val)
  );

endmodule

// File: tb/tb_onewire_rom_reader.sv
// Bench for onewire_rom_reader: a behavioural 1-Wire ROM device on a shared
// wired-AND bus, two masters (full 8-byte reader with CRC, 2-byte reader
// without), and a scoreboard of expected values computed from the ROM image.
module tb_onewire_rom_reader;

  localparam int CLK_HZ = 2_000_000;
  localparam int DIV    = CLK_HZ / 1_000_000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        go_a = 1'b0, go_b = 1'b0;
  logic        dq_i;
  logic        dq_oe_a, busy_a, done_a, err_np_a, err_crc_a, valid_a;
  logic [63:0] data_a;
  logic        dq_oe_b, busy_b, done_b, err_np_b, err_crc_b, valid_b;
  logic [15:0] data_b;
  logic        dev_pull = 1'b0;

  assign dq_i = ~(dq_oe_a | dq_oe_b | dev_pull);

  onewire_rom_reader #(.CLK_HZ(CLK_HZ)) dut_a (
    .clk(clk), .reset(rst_a), .go(go_a), .dq_i(dq_i), .dq_oe(dq_oe_a),
    .busy(busy_a), .done(done_a), .err_nopresence(err_np_a),
    .err_crc(err_crc_a), .data(data_a), .valid(valid_a)
  );

  onewire_rom_reader #(.CLK_HZ(CLK_HZ), .NBYTES(2), .CRC_CHECK(0)) dut_b (
    .clk(clk), .reset(rst_b), .go(go_b), .dq_i(dq_i), .dq_oe(dq_oe_b),
    .busy(busy_b), .done(done_b), .err_nopresence(err_np_b),
    .err_crc(err_crc_b), .data(data_b), .valid(valid_b)
  );

  // ---------------- device model ----------------
  logic [7:0] rom [8];
  bit         dev_present = 1'b1;
  longint     cyc = 0, pres_start = 0, pres_end = 0, rd_until = 0;
  int         low_cnt = 0, slot_idx = 0, rd_idx = 0;
  logic       oe_prev = 1'b0;
  logic [7:0] dev_cmd = 8'h00;

  function automatic logic rom_bit(input int k);
    logic [7:0] b;
    b = rom[k / 8];
    return b[k % 8];
  endfunction

  // Byte-wise Dallas CRC over the first n ROM bytes
  function automatic logic [7:0] crc_of(input int n);
    logic [7:0] c, b;
    logic       mix;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = rom[i];
      for (int k = 0; k < 8; k++) begin
        mix = c[0] ^ b[0];
        c   = c >> 1;
        if (mix) c = c ^ 8'h8C;
        b   = b >> 1;
      end
    end
    return c;
  endfunction

  // Slave behaviour: detects reset by low length, answers presence,
  // decodes write slots by low length, holds the bus for read-0 slots.
  always @(negedge clk) begin
    logic bus_oe;
    bus_oe = dq_oe_a | dq_oe_b;
    cyc++;
    if (bus_oe) low_cnt++;
    if (bus_oe && !oe_prev && slot_idx >= 8 && rd_idx < 64) begin
      if (!rom_bit(rd_idx)) rd_until = cyc + 30 * DIV;
      rd_idx++;
    end
    if (!bus_oe && oe_prev) begin
      if (low_cnt >= 400 * DIV) begin
        pres_start = cyc + 20 * DIV;
        pres_end   = cyc + 120 * DIV;
        slot_idx   = 0;
        rd_idx     = 0;
        rd_until   = 0;
        dev_cmd    = 8'h00;
      end else if (slot_idx < 8) begin
        dev_cmd[slot_idx] = (low_cnt < 15 * DIV);
        slot_idx++;
      end
      low_cnt = 0;
    end
    oe_prev  = bus_oe;
    dev_pull = dev_present && ((cyc >= pres_start && cyc < pres_end) || cyc < rd_until);
  end

  // ---------------- bus / done monitor ----------------
  int     width_q[$];
  longint rise_q[$];
  int     hi_cnt = 0, done_cnt_a = 0, done_cnt_b = 0;
  longint mcyc = 0;
  logic   a_prev = 1'b0;

  always @(negedge clk) begin
    mcyc++;
    if (go_a) begin
      width_q.delete();
      rise_q.delete();
    end
    if (dq_oe_a) hi_cnt++;
    if (dq_oe_a && !a_prev) rise_q.push_back(mcyc);
    if (!dq_oe_a && a_prev) width_q.push_back(hi_cnt);
    if (!dq_oe_a) hi_cnt = 0;
    a_prev = dq_oe_a;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_go_a();
    @(posedge clk); #1 go_a = 1'b1;
    @(posedge clk); #1 go_a = 1'b0;
  endtask

  task automatic pulse_go_b();
    @(posedge clk); #1 go_b = 1'b1;
    @(posedge clk); #1 go_b = 1'b0;
  endtask

  task automatic wait_done(input bit which_b, input int limit, output int n, output bit seen);
    seen = 1'b0;
    n    = 0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (which_b ? done_b : done_a) seen = 1'b1;
    end
  endtask

  task automatic random_rom();
    for (int i = 0; i < 7; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[7] = crc_of(7);
    if ($urandom_range(0, 1) == 1)
      rom[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
  endtask

  task automatic run_a(input string tag, output int n);
    logic [63:0] exp_data;
    bit          crc_ok, seen;
    for (int i = 0; i < 8; i++) exp_data[8*i +: 8] = rom[i];
    crc_ok = (crc_of(8) == 8'h00);
    pulse_go_a();
    wait_done(1'b0, 20000, n, seen);
    check_eq({tag, " done"}, seen, 1);
    check_eq({tag, " busy"}, busy_a, 0);
    check_eq({tag, " err_np"}, err_np_a, !dev_present);
    if (dev_present) begin
      check_eq({tag, " err_crc"}, err_crc_a, !crc_ok);
      check_eq({tag, " valid"}, valid_a, crc_ok);
      check_eq({tag, " data"}, data_a, exp_data);
      check_eq({tag, " cmd"}, dev_cmd, 8'h33);
    end else begin
      check_eq({tag, " err_crc"}, err_crc_a, 0);
      check_eq({tag, " valid"}, valid_a, 0);
      check_eq({tag, " low_pulses"}, width_q.size(), 1);
    end
    @(negedge clk);
    check_eq({tag, " done_pulse"}, done_a, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n, dcnt;
    bit         seen;
    logic [7:0] cmd_v;
    cmd_v = 8'h33;

    repeat (4) @(posedge clk);
    #1;
    check_eq("reset ctl_a", {dq_oe_a, busy_a, done_a, err_np_a, err_crc_a, valid_a}, 0);
    check_eq("reset data_a", data_a, 0);
    check_eq("reset ctl_b", {dq_oe_b, busy_b, done_b, err_np_b, err_crc_b, valid_b, data_b}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (10) @(posedge clk);

    // AN27 example ROM, with bus timing checks
    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
    run_a("an27", n);
    check_eq("an27 data_const", data_a, 64'hA2000000_01B81C02);
    check_eq("an27 low_pulses", width_q.size(), 73);
    if (width_q.size() == 73 && rise_q.size() == 73) begin
      check_eq("an27 rstl_us", (width_q[0] + DIV - 1) / DIV, 480);
      for (int i = 1; i <= 8; i++) begin
        check_eq($sformatf("an27 wr%0d_low", i - 1), width_q[i], cmd_v[i-1] ? 6 * DIV : 60 * DIV);
        check_eq($sformatf("an27 slot%0d_period", i), rise_q[i+1] - rise_q[i], 70 * DIV);
      end
      check_eq("an27 rd_low", width_q[9], 6 * DIV);
    end

    // Same ROM with a corrupted CRC byte
    rom[7] = 8'hA3;
    run_a("badcrc", n);
    check_eq("badcrc data_const", data_a, 64'hA3000000_01B81C02);

    // No device on the bus
    dev_present = 1'b0;
    run_a("nodev", n);
    check_eq("nodev done_us_ok", (n >= 545 * DIV && n <= 555 * DIV), 1);
    if (width_q.size() >= 1)
      check_eq("nodev rstl_us", (width_q[0] + DIV - 1) / DIV, 480);
    dev_present = 1'b1;

    // Reset 100 us into the read phase
    random_rom();
    pulse_go_a();
    repeat (1550 * DIV) @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (dq_oe_a) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("rstmid oe_found", seen, 1);
    dcnt  = done_cnt_a;
    rst_a = 1'b1;
    #1;
    check_eq("rstmid dq_oe", dq_oe_a, 0);
    check_eq("rstmid busy", busy_a, 0);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    repeat (400) @(negedge clk);
    check_eq("rstmid no_done", done_cnt_a, dcnt);

    // Random ROM images, some corrupted
    for (int t = 0; t < 2; t++) begin
      random_rom();
      run_a($sformatf("rand%0d", t), n);
    end

    // Short reader without CRC; extra go pulses while busy are ignored
    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
    dcnt = done_cnt_b;
    pulse_go_b();
    repeat (1000) @(posedge clk);
    pulse_go_b();
    repeat (1500) @(posedge clk);
    pulse_go_b();
    wait_done(1'b1, 4000, n, seen);
    check_eq("busygo done", seen, 1);
    check_eq("busygo latency_ok", (n + 2504 >= 2560 * DIV && n + 2504 <= 2580 * DIV), 1);
    check_eq("busygo data", data_b, 16'h1C02);
    check_eq("busygo valid", valid_b, 1);
    check_eq("busygo errs", {err_np_b, err_crc_b}, 0);
    repeat (300) @(negedge clk);
    check_eq("busygo done_count", done_cnt_b - dcnt, 1);
    check_eq("busygo idle", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
